serial_add_ctrl: RTL and testbench

- Sequencer that reuses one single-bit full adder slice to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
- Owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Sits between a requesting controller and the existing 1-bit full-adder datapath.
- Trades WIDTH cycles of latency for a single adder slice.

---
 rtl/serial_add_ctrl_if.sv | 35 +++
 rtl/serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a controller and the bit-serial adder.
// The controller side (master) drives start and operands; the adder side
// (slave) returns busy/done and the held result.
// Optional macro SERIAL_ADD_SUB_EN adds the 1-bit sub request line.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice adds two WIDTH-bit
// operands LSB first, one bit per clock, with a start/busy/done handshake.
// A start accepted at edge k produces done in the cycle after edge k+WIDTH
// and the block is back in IDLE after edge k+WIDTH+1.
// Optional macro SERIAL_ADD_SUB_EN: adds a sub request that computes a-b
// by loading ~b with a carry-in of 1 (cout=1 then means no borrow).
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] cnt;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  // Single full-adder slice: returns {carry_out, sum_bit}.
  function automatic logic [1:0] fa_slice(input logic x, input logic y,
                                          input logic ci);
    logic s;
    logic c;
    s = x ^ y ^ ci;
    c = (x & y) | (x & ci) | (y & ci);
    return {c, s};
  endfunction

  // The shared slice always looks at the current LSBs and the carry FF.
  always_comb begin
    {c_bit, s_bit} = fa_slice(op_a[0], op_b[0], carry);
  end

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1; cin is ignored for a subtract request.
  always_comb begin
    load_b = bus.b;
    load_c = bus.cin;
    if (bus.sub) begin
      load_b = ~bus.b;
      load_c = 1'b1;
    end
  end
`else
  // Add-only build: operands and carry-in load unchanged.
  always_comb begin
    load_b = bus.b;
    load_c = bus.cin;
  end
`endif

  // Sequencer: operand shifting, carry, counter, result and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_a   <= bus.a;
            op_b   <= load_b;
            carry  <= load_c;
            sum_r  <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          // Each result bit enters at the MSB; after WIDTH shifts the LSB
          // computed first has reached bit 0.
          sum_r <= {s_bit, sum_r[WIDTH-1:1]};
          carry <= c_bit;
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            cout_r <= c_bit;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          // start is ignored here; a held start is taken on the next IDLE edge.
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with hand-computed results.
// Optional macro SERIAL_ADD_SUB_EN: also exercises the subtract request.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sub(input logic sb);
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sb;
`else
    if (sb) $display("note: sub requested in add-only build");
`endif
  endtask

  // Align to just after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE, checking latency, result and flags.
  task automatic run_add(input string tag, input logic [7:0] av,
                         input logic [7:0] bv, input logic ci, input logic sb,
                         input logic [7:0] es, input logic ec);
    int lat;
    tick();
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    set_sub(sb);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int wide;
    int last;
    int gap_bad;
    int sum_bad;
    int done_seen;
    logic prev;
    logic [7:0] sum_at_done;

    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    set_sub(1'b0);

    // Reset state
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    #10;
    rst_n = 1'b1;

    // Basic adds
    run_add("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);

    // Start pulsed mid-RUN must be ignored
    tick();
    bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    bus.a = 8'h00; bus.b = 8'h00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    sum_at_done = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        pulses++;
        sum_at_done = bus.sum;
      end
      tick();
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_sum", 32'(sum_at_done), 32'h8D);
    chk("ignore_busy", 32'(bus.busy), 32'd0);

    // Overflow wraps, carry only on cout
    run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_add("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset mid-RUN
    tick();
    bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_sum", 32'(bus.sum), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    #2;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    chk("arst_no_done", 32'(done_seen), 32'd0);
    run_add("add_12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

    // Start held continuously: one add every WIDTH+2 cycles
    tick();
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
    pulses = 0; wide = 0; last = -1; gap_bad = 0; sum_bad = 0;
    prev = 1'b0;
    for (int c = 0; c < 46; c++) begin
      tick();
      if (bus.done) begin
        if (prev) wide++;
        if (last >= 0 && (c - last) != WIDTH + 2) gap_bad++;
        if (bus.sum !== 8'h02) sum_bad++;
        last = c;
        pulses++;
      end
      prev = bus.done;
    end
    bus.start = 1'b0;
    chk("stream_pulses", 32'(pulses), 32'd4);
    chk("stream_gap", 32'(gap_bad), 32'd0);
    chk("stream_wide", 32'(wide), 32'd0);
    chk("stream_sum", 32'(sum_bad), 32'd0);
    for (int i = 0; i < 20 && bus.busy; i++) tick();
    chk("stream_idle", 32'(bus.busy), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction requests
    run_add("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_add("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_add("sub0_add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
